// File: rtl/prio_enc_pipe.sv
//=============================================================================
// Module      : prio_enc_pipe
// Description : Priority encoder with one-stage valid/ready output register.
//               The highest-index set bit of din wins by default. Defining
//               the macro PRIO_ENC_RR_EN selects rotating (round-robin)
//               priority, where the search starts at a pointer that moves
//               to just below the last winner.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module prio_enc_pipe #(
   parameter int WIDTH = 8,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDXW-1:0]  out_idx,
   output logic             out_found,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t            state_q;
   logic [IDXW-1:0]   out_idx_q;
   logic              out_found_q;

   logic [IDXW-1:0]   win_idx_d;
   logic              win_any_d;
   logic              found_d;
   logic [IDXW-1:0]   idx_d;
   logic              accept_w;

   // Handshake: a slot is free when nothing is held or the holder is leaving
   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept_w  = in_valid && in_ready;
   assign out_idx   = out_idx_q;
   assign out_found = out_found_q;

`ifdef PRIO_ENC_RR_EN
   logic [IDXW-1:0]   ptr_q;
   logic [IDXW-1:0]   rr_pos_d;

   // Rotating search: visit ptr, ptr-1, ... wrapping; later hits in the loop
   // have higher priority, so the loop runs from lowest to highest priority
   always_comb begin
      win_idx_d = '0;
      win_any_d = 1'b0;
      rr_pos_d  = '0;
      for (int j = WIDTH - 1; j >= 0; j--) begin
         rr_pos_d = IDXW'((int'(ptr_q) + WIDTH - j) % WIDTH);
         if (din[rr_pos_d]) begin
            win_idx_d = rr_pos_d;
            win_any_d = 1'b1;
         end
      end
   end
`else
   // Fixed search: the highest-index set bit overrides lower ones
   always_comb begin
      win_idx_d = '0;
      win_any_d = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) begin
            win_idx_d = IDXW'(i);
            win_any_d = 1'b1;
         end
      end
   end
`endif

   // A disabled or empty request reports index 0 with found cleared
   always_comb begin
      found_d = en && win_any_d;
      idx_d   = found_d ? win_idx_d : '0;
   end

   // Output stage state, result register and (optionally) rotation pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         out_idx_q   <= '0;
         out_found_q <= 1'b0;
`ifdef PRIO_ENC_RR_EN
         ptr_q       <= IDXW'(WIDTH - 1);
`endif
      end else begin
         if (accept_w) begin
            state_q     <= FULL;
            out_idx_q   <= idx_d;
            out_found_q <= found_d;
`ifdef PRIO_ENC_RR_EN
            if (found_d) begin
               ptr_q <= (win_idx_d == '0) ? IDXW'(WIDTH - 1) : (win_idx_d - 1'b1);
            end
`endif
         end else if (out_ready) begin
            // Transfer without a new accept empties the stage; data is kept
            state_q <= EMPTY;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_prio_enc_pipe.sv
//=============================================================================
// Module      : tb_prio_enc_pipe
// Description : Scoreboard bench for prio_enc_pipe (WIDTH=8). The round-robin
//               sequence runs when PRIO_ENC_RR_EN is defined.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_prio_enc_pipe;

   localparam int WIDTH = 8;
   localparam int IDXW  = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] din;
   logic             in_valid;
   logic             in_ready;
   logic [IDXW-1:0]  out_idx;
   logic             out_found;
   logic             out_valid;
   logic             out_ready;

   typedef struct packed {
      logic [IDXW-1:0] idx;
      logic            found;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   prio_enc_pipe #(.WIDTH(WIDTH), .IDXW(IDXW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .din       (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_idx   (out_idx),
      .out_found (out_found),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop one expected entry for every transfer the DUT makes
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got idx=%0d found=%0d expected none at %0t",
                     out_idx, out_found, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_idx", 32'(out_idx), 32'(e.idx));
            chk("out_found", 32'(out_found), 32'(e.found));
         end
      end
   end

   // Present one vector; push its expectation on the cycle it is accepted
   task automatic send(input logic [7:0] d, input logic e, input logic [2:0] xi, input logic xf);
      int waitc;
      waitc    = 0;
      din      = d;
      en       = e;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         waitc++;
         if (waitc > 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got no accept expected accept of din=%h", d);
            in_valid = 1'b0;
            return;
         end
      end
      sb.push_back('{idx: xi, found: xf});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n         = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_queue_empty", 32'(sb.size()), 32'd0);
      chk("drain_valid_low", 32'(out_valid), 32'd0);
   endtask

   logic [7:0] tp_din [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h03, 8'hC0};
   logic [2:0] tp_idx [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
                               3'd5, 3'd6, 3'd7, 3'd1, 3'd7};

   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      din       = '0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_idx", 32'(out_idx), 32'd0);
      chk("reset_out_found", 32'(out_found), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;

`ifdef PRIO_ENC_RR_EN
      // Rotating priority starting from ptr=7
      send(8'hFF, 1'b1, 3'd7, 1'b1);
      send(8'hFF, 1'b1, 3'd6, 1'b1);
      send(8'hFF, 1'b1, 3'd5, 1'b1);
      send(8'hFF, 1'b1, 3'd4, 1'b1);
      send(8'h81, 1'b1, 3'd0, 1'b1);
      send(8'h81, 1'b1, 3'd7, 1'b1);
      drain();
`else
      // Basic encode with one-cycle latency
      send(8'b0010_0100, 1'b1, 3'd5, 1'b1);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_idx", 32'(out_idx), 32'd5);
      drain();

      // Disabled and empty requests, then the lowest bit
      send(8'hFF, 1'b0, 3'd0, 1'b0);
      send(8'h00, 1'b1, 3'd0, 1'b0);
      send(8'h01, 1'b1, 3'd0, 1'b1);
      drain();

      // Backpressure: result held stable, input refused until out_ready
      out_ready = 1'b0;
      send(8'h80, 1'b1, 3'd7, 1'b1);
      din      = 8'h01;
      en       = 1'b1;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_idx", 32'(out_idx), 32'd7);
         chk("stall_found", 32'(out_found), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h01, 1'b1, 3'd0, 1'b1);
      chk("release_valid", 32'(out_valid), 32'd1);
      chk("release_idx", 32'(out_idx), 32'd0);
      drain();

      // Full throughput: ten back-to-back results
      out_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 10; k++) send(tp_din[k], 1'b1, tp_idx[k], 1'b1);
         end
         begin
            @(posedge clk);
            repeat (10) begin
               @(negedge clk);
               chk("throughput_valid", 32'(out_valid), 32'd1);
            end
         end
      join
      drain();
`endif

      // Asynchronous reset with a held result
      out_ready = 1'b0;
      send(8'h40, 1'b1, 3'd6, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_idx", 32'(out_idx), 32'd0);
      chk("async_rst_found", 32'(out_found), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("no_stale_valid", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      send(8'h02, 1'b1, 3'd1, 1'b1);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire

// File: doc/prio_enc_pipe.md
PRIO_ENC_PIPE -- requirements
Module: prio_enc_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of request bits (legal range 2..64).
REQ-002 The block SHALL have parameter IDXW, default $clog2(WIDTH), output index width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port en  input  1  encode enable, sampled with din on accept.
REQ-006 The block SHALL have port din  input  WIDTH  request vector; bit WIDTH-1 has the highest fixed priority.
REQ-007 The block SHALL have port in_valid  input  1  din/en are valid this cycle.
REQ-008 The block SHALL have port in_ready  output  1  the block accepts din/en this cycle.
REQ-009 The block SHALL have port out_idx  output  IDXW  encoded index of the winning bit.
REQ-010 The block SHALL have port out_found  output  1  at least one qualifying bit was set and en was 1.
REQ-011 The block SHALL have port out_valid  output  1  out_idx/out_found hold a result.
REQ-012 The block SHALL have port out_ready  input  1  the consumer takes the result this cycle.

Function
REQ-013 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (!out_valid || out_ready), combinationally; no input is accepted while a result is held and not consumed.
REQ-015 Latency SHALL be exactly 1 cycle: the result of an accept is presented with out_valid=1 on the cycle after the accept edge.
REQ-016 On an accept with en=1 and din!=0, out_idx SHALL be the index of the winning set bit and out_found SHALL be 1.
REQ-017 On an accept with en=0, or with din=0, out_idx SHALL be 0 and out_found SHALL be 0.
REQ-018 On an edge with a transfer and no accept, out_valid SHALL go to 0, and out_idx/out_found SHALL keep their values.
REQ-019 On an edge with both a transfer and an accept, the new result SHALL load and out_valid SHALL stay 1, giving full throughput of 1 result per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_idx and out_found SHALL be stable, regardless of din, en or in_valid.
REQ-021 Without an accept, out_idx and out_found SHALL hold their values; when out_valid=0 their values are don't-care but SHALL be deterministic.
REQ-022 The block SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL on accept.
- FULL->EMPTY on transfer without accept.
- FULL->FULL on accept with transfer, or on stall.

Reset
REQ-023 While rst_n=0, the block SHALL drive out_valid=0, out_idx=0 and out_found=0, independent of clk.
REQ-024 Asserting rst_n mid-operation SHALL discard any held result; no transfer is reported for it.
REQ-025 After rst_n deasserts, the first accept SHALL be possible on the first rising edge where in_valid=1.
REQ-026 With PRIO_ENC_RR_EN, reset SHALL set the rotation pointer ptr to WIDTH-1.

Configuration
REQ-027 Macro PRIO_ENC_RR_EN SHALL select round-robin mode.
- Undefined: fixed priority; the winning bit is the highest-index set bit of din, and the block has no ptr register.
- Defined: rotating priority; ptr (IDXW bits) marks the highest-priority index.
- The search runs ptr, ptr-1, ..., 0, WIDTH-1, ..., ptr+1, wrapping at 0.
REQ-028 With PRIO_ENC_RR_EN, an accept with out_found=1 at winning index k SHALL set ptr to k-1, or to WIDTH-1 when k=0.
REQ-029 With PRIO_ENC_RR_EN, ptr SHALL NOT change on accepts with en=0, din=0, or with no accept.
REQ-030 The port list SHALL be identical with and without PRIO_ENC_RR_EN.

Verification (WIDTH=8)
REQ-031 The bench SHALL apply: accept din=8'b0010_0100, en=1, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_found=1.
REQ-032 The bench SHALL apply: accept din=8'hFF, en=0, then din=8'h00, en=1 -> both give out_idx=0, out_found=0; then din=8'h01, en=1 -> out_idx=0, out_found=1.
REQ-033 The bench SHALL apply: accept din=8'h80, hold out_ready=0 for 3 cycles while presenting din=8'h01 -> in_ready=0, out_idx=7 stable; raise out_ready -> 8'h01 is accepted on the same edge, out_idx=0 next cycle.
REQ-034 The bench SHALL apply: in_valid=1 and out_ready=1 every cycle for 10 cycles -> 10 results on consecutive cycles, out_valid never drops.
REQ-035 The bench SHALL apply: with a result held, pulse rst_n low mid-cycle -> out_valid=0 immediately; no stale result after release.
REQ-036 The bench SHALL apply, with PRIO_ENC_RR_EN: four accepts of din=8'hFF -> out_idx 7,6,5,4; then accept din=8'h81 -> out_idx=0; then din=8'h81 -> out_idx=7.
